// File: rtl/joypad_pkg.sv
// Shared constants for the NES joypad block: button bit positions,
// scanner state encoding and CPU register selects.
package joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int NUM_BTNS = 8;

  localparam logic JP_REG_4016 = 1'b0;
  localparam logic JP_REG_4017 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SAMPLE = 3'd2,
    S_CLKH   = 3'd3,
    S_CLKL   = 3'd4,
    S_COMMIT = 3'd5
  } scan_state_t;

endpackage

// File: rtl/joypad_if.sv
// CPU-side register bus for $4016/$4017. Strobes arrive already decoded;
// d_out must read as zero when rd_in is low because the bus is OR-muxed.
interface joypad_if;
  logic       wr_in;
  logic       rd_in;
  logic       a_in;
  logic [7:0] d_in;
  logic [7:0] d_out;

  modport master (output wr_in, output rd_in, output a_in, output d_in, input d_out);
  modport slave  (input wr_in, input rd_in, input a_in, input d_in, output d_out);
endinterface

// File: rtl/joypad_scan.sv
// Periodic pad scanner: latches both pads, clocks out 8 bits serially and
// commits the decoded (active-high) button state atomically at scan end.
module joypad_scan
  import joypad_pkg::*;
#(
  parameter int POLL_PERIOD = 1666667,
  parameter int HALF_BIT    = 300
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       i_data1,
  input  logic       i_data2,
  output logic       o_jp_clk,
  output logic       o_jp_latch,
  output logic [7:0] o_pad1_state,
  output logic [7:0] o_pad2_state
);

  localparam int CNT_W  = $clog2(2*HALF_BIT + 1);
  localparam int POLL_W = $clog2(POLL_PERIOD + 1);

  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(2*HALF_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_BIT - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

  scan_state_t       r_state, w_next;
  logic [POLL_W-1:0] r_poll;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_sh1, r_sh2;
  logic [7:0]        r_pad1, r_pad2;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_poll == POLL_LAST) w_next = S_LATCH;
      S_LATCH:  if (r_cnt == LATCH_LAST) w_next = S_SAMPLE;
      S_SAMPLE: w_next = (r_bit == 3'd7) ? S_COMMIT : S_CLKH;
      S_CLKH:   if (r_cnt == HALF_LAST) w_next = S_CLKL;
      S_CLKL:   if (r_cnt == HALF_LAST) w_next = S_SAMPLE;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_poll <= '0;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sh1  <= '0;
      r_sh2  <= '0;
      r_pad1 <= '0;
      r_pad2 <= '0;
    end else begin
      r_poll <= (r_state == S_IDLE && r_poll != POLL_LAST) ? r_poll + 1'b1 : '0;
      // Per-state dwell counter restarts on every state change.
      r_cnt  <= (r_state == S_IDLE || w_next != r_state) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_LATCH:  r_bit <= '0;
        S_SAMPLE: begin
          r_sh1[r_bit] <= ~i_data1;
          r_sh2[r_bit] <= ~i_data2;
        end
        S_CLKL:   if (w_next == S_SAMPLE) r_bit <= r_bit + 3'd1;
        S_COMMIT: begin
          r_pad1 <= r_sh1;
          r_pad2 <= r_sh2;
        end
        default: ;
      endcase
    end
  end

  // Decoded from the state register so reset drops the pins asynchronously.
  assign o_jp_clk     = (r_state == S_CLKH);
  assign o_jp_latch   = (r_state == S_LATCH);
  assign o_pad1_state = r_pad1;
  assign o_pad2_state = r_pad2;

endmodule

// File: rtl/joypad_ctrl.sv
// $4016/$4017 front-end: strobe bit, 4021-style CPU shift registers and the
// OR-muxable read path, fed by the background pad scanner.
module joypad_ctrl
  import joypad_pkg::*;
#(
  parameter int POLL_PERIOD = 1666667,
  parameter int HALF_BIT    = 300
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     jp_data1_in,
  input  logic     jp_data2_in,
  joypad_if.slave  bus,
  output logic     jp_clk,
  output logic     jp_latch
);

  logic [7:0] w_pad1_state, w_pad2_state;
  logic       r_strobe;
  logic [7:0] r_sr1, r_sr2;
  logic       w_sel_bit;
  logic       w_unused;

  joypad_scan #(
    .POLL_PERIOD (POLL_PERIOD),
    .HALF_BIT    (HALF_BIT)
  ) u_scan (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_data1      (jp_data1_in),
    .i_data2      (jp_data2_in),
    .o_jp_clk     (jp_clk),
    .o_jp_latch   (jp_latch),
    .o_pad1_state (w_pad1_state),
    .o_pad2_state (w_pad2_state)
  );

  assign w_unused = ^bus.d_in[7:1];

  // Strobe high exposes the live A button; otherwise the shift register head.
  always_comb begin
    w_sel_bit = 1'b0;
    if (bus.a_in == JP_REG_4016) w_sel_bit = r_strobe ? w_pad1_state[BTN_A] : r_sr1[0];
    else                         w_sel_bit = r_strobe ? w_pad2_state[BTN_A] : r_sr2[0];
  end

  assign bus.d_out = bus.rd_in ? {7'b0, w_sel_bit} : 8'h00;

  // Load and shift decisions use the pre-write strobe, so a write of 0
  // still gets its final load and a same-cycle read never sees the new value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_strobe <= 1'b0;
      r_sr1    <= '0;
      r_sr2    <= '0;
    end else begin
      if (bus.wr_in && bus.a_in == JP_REG_4016) r_strobe <= bus.d_in[0];
      if (r_strobe) begin
        r_sr1 <= w_pad1_state;
        r_sr2 <= w_pad2_state;
      end else if (bus.rd_in) begin
        if (bus.a_in == JP_REG_4016) r_sr1 <= {1'b1, r_sr1[7:1]};
        else                         r_sr2 <= {1'b1, r_sr2[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_joypad_ctrl.sv
// Directed bench for joypad_ctrl: pad models, scan timing checks and a
// read-data scoreboard drained by an independent monitor.
module tb_joypad_ctrl;
  localparam int PP = 100;
  localparam int H  = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic jp_data1_in, jp_data2_in, jp_clk, jp_latch;

  joypad_if bus();

  joypad_ctrl #(.POLL_PERIOD(PP), .HALF_BIT(H)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .jp_data1_in (jp_data1_in),
    .jp_data2_in (jp_data2_in),
    .bus         (bus),
    .jp_clk      (jp_clk),
    .jp_latch    (jp_latch)
  );

  always #5 clk_in = ~clk_in;

  // 4021-like pad: latch resets the bit index, each jp_clk rise advances it.
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic [3:0] idx = 4'd0;
  logic       prev_jclk = 1'b0;
  always @(posedge clk_in) begin
    prev_jclk <= jp_clk;
    if (jp_latch) idx <= 4'd0;
    else if (jp_clk && !prev_jclk) idx <= idx + 4'd1;
  end
  always_comb begin
    jp_data1_in = 1'b1;
    jp_data2_in = 1'b1;
    if (idx < 4'd8) begin
      jp_data1_in = ~btn1[idx[2:0]];
      jp_data2_in = ~btn2[idx[2:0]];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [7:0] val;
    int         tag;
  } exp_t;
  exp_t q[$];
  int   rtag = 0;

  // Monitor: every read cycle pops one expectation; the cycle after a read
  // must show the bus back at zero.
  logic prev_rd = 1'b0;
  always @(negedge clk_in) begin
    exp_t e;
    if (bus.rd_in) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got %0h expected no read at %0t", bus.d_out, $time);
      end else begin
        e = q.pop_front();
        chk($sformatf("read%0d", e.tag), {24'b0, bus.d_out}, {24'b0, e.val});
      end
    end else if (prev_rd) begin
      chk("idle_dout", {24'b0, bus.d_out}, 32'h0);
    end
    prev_rd <= bus.rd_in;
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic b);
    exp_t e;
    e.val = {7'b0, b};
    e.tag = rtag++;
    q.push_back(e);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.wr_in = 1'b1; bus.rd_in = 1'b0; bus.a_in = a; bus.d_in = d;
    cyc();
    bus.wr_in = 1'b0;
  endtask

  task automatic rd(input logic a, input logic b);
    bus.rd_in = 1'b1; bus.wr_in = 1'b0; bus.a_in = a;
    push(b);
    cyc();
  endtask

  task automatic rdwr(input logic a, input logic [7:0] d, input logic b);
    bus.rd_in = 1'b1; bus.wr_in = 1'b1; bus.a_in = a; bus.d_in = d;
    push(b);
    cyc();
    bus.wr_in = 1'b0;
  endtask

  task automatic idle();
    bus.rd_in = 1'b0; bus.wr_in = 1'b0;
    cyc();
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!jp_latch && n < 2000);
  endtask

  // Called just after latch rises; returns latch length, jp_clk pulse count
  // and mismatches against the expected jp_clk waveform, ending after commit.
  task automatic scan_meas(output int llen, output int pulses, output int mism);
    logic pc, ep;
    llen = 1; pulses = 0; mism = 0; pc = 1'b0;
    while (llen < 50) begin
      cyc();
      if (jp_latch) llen++;
      else break;
    end
    for (int p = 0; p < 65; p++) begin
      ep = (p < 63) && (p % 9 >= 1) && (p % 9 <= 4);
      if (jp_clk !== ep) mism++;
      if (jp_clk && !pc) pulses++;
      pc = jp_clk;
      cyc();
    end
  endtask

  initial begin
    int n, ll, pu, mm;
    logic [7:0] seq10;
    bus.wr_in = 1'b0; bus.rd_in = 1'b0; bus.a_in = 1'b0; bus.d_in = 8'h00;

    #2;
    chk("rst_jp_clk",   {31'b0, jp_clk}, 32'd0);
    chk("rst_jp_latch", {31'b0, jp_latch}, 32'd0);
    chk("rst_dout",     {24'b0, bus.d_out}, 32'd0);
    chk("rst_pad1",     {24'b0, dut.w_pad1_state}, 32'd0);
    chk("rst_pad2",     {24'b0, dut.w_pad2_state}, 32'd0);

    #18 rst_in = 1'b0;
    wait_latch(n);
    chk("latch_delay", n, 32'd100);
    scan_meas(ll, pu, mm);
    chk("latch_len", ll, 32'd8);
    chk("clk_pulses", pu, 32'd7);
    chk("clk_wave_mism", mm, 32'd0);
    chk("scan1_pad1", {24'b0, dut.w_pad1_state}, 32'h00);
    chk("scan1_pad2", {24'b0, dut.w_pad2_state}, 32'h00);

    // A, Start, Right on pad 1
    btn1 = 8'h89;
    wait_latch(n);
    chk("latch_period", n, 32'd100);
    scan_meas(ll, pu, mm);
    chk("scan2_pad1", {24'b0, dut.w_pad1_state}, 32'h89);
    chk("scan2_pad2", {24'b0, dut.w_pad2_state}, 32'h00);

    wr(1'b0, 8'h01);
    wr(1'b0, 8'h00);
    seq10 = 8'h89;
    for (int i = 0; i < 10; i++) rd(1'b0, (i < 8) ? seq10[i] : 1'b1);
    idle();

    // strobe held high: reads show live A and never shift
    wr(1'b0, 8'h01);
    rd(1'b0, 1'b1); rd(1'b0, 1'b1); rd(1'b0, 1'b1);
    idle();
    // read + write 0 together: pre-write strobe value, final load, no shift
    rdwr(1'b0, 8'h00, 1'b1);
    rd(1'b0, 1'b1); rd(1'b0, 1'b0);
    idle();

    btn2 = 8'h02;
    wait_latch(n);
    scan_meas(ll, pu, mm);
    chk("scan3_pad2", {24'b0, dut.w_pad2_state}, 32'h02);

    wr(1'b0, 8'h01);
    wr(1'b0, 8'h00);
    rd(1'b1, 1'b0); rd(1'b0, 1'b1);
    rd(1'b1, 1'b1); rd(1'b0, 1'b0);
    rd(1'b1, 1'b0); rd(1'b0, 1'b0);
    rd(1'b1, 1'b0); rd(1'b0, 1'b1);
    idle();
    // a write to $4017 must not touch the strobe
    wr(1'b1, 8'h01);
    rd(1'b0, 1'b0);
    idle();

    // reset in the middle of bit 3's clock-high phase
    wait_latch(n);
    n = 0;
    pu = 0;
    begin
      logic pc = 1'b0;
      while (pu < 4 && n < 200) begin
        cyc();
        n++;
        if (jp_clk && !pc) pu++;
        pc = jp_clk;
      end
    end
    chk("reach_bit3_clkh", pu, 32'd4);
    cyc();
    #2 rst_in = 1'b1;
    #1;
    chk("mid_rst_jp_clk",   {31'b0, jp_clk}, 32'd0);
    chk("mid_rst_jp_latch", {31'b0, jp_latch}, 32'd0);
    chk("mid_rst_pad1",     {24'b0, dut.w_pad1_state}, 32'h00);
    chk("mid_rst_pad2",     {24'b0, dut.w_pad2_state}, 32'h00);
    @(negedge clk_in);
    rst_in = 1'b0;
    wait_latch(n);
    chk("post_rst_latch_delay", n, 32'd100);
    rd(1'b0, 1'b0); rd(1'b1, 1'b0);
    idle();
    scan_meas(ll, pu, mm);
    chk("post_rst_pad1", {24'b0, dut.w_pad1_state}, 32'h89);

    repeat (3) cyc();
    chk("sb_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
